uart_rx: RTL and testbench

- UART receiver; the receive-side counterpart of the team's uart_tx.
- Takes the serial line, synchronises it, and detects start bits.
- Samples data, parity and stop bits mid-bit and delivers each word through a one-deep holding register with a level valid/ack handshake.
- Frame format matches uart_tx: same clk_div, bits_per_word, parity and stop-bit controls, so one register set drives both.

---
 rtl/uart_rx.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, samples each bit mid-cell and hands completed words
// to the consumer through a one-deep holding register with a level valid/ack handshake.
module uart_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] clk_div,
  input  logic [4:0]  bits_per_word,
  input  logic        parity_en,
  input  logic        parity_even_odd,
  input  logic        two_stop_bit,
  input  logic        rd_ack,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun_err,
  output logic        busy
);

  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StStop2} state_e;

  logic [Stages-1:0] sync_q;
  logic              rx_s;
  logic              rx_prev_q;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic        par_q, par_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;

  logic [15:0] cfg_div_q, cfg_div_d;
  logic [4:0]  cfg_bpw_q, cfg_bpw_d;
  logic        cfg_pen_q, cfg_pen_d;
  logic        cfg_even_q, cfg_even_d;
  logic        cfg_two_q, cfg_two_d;

  logic [15:0] data_out_q, data_out_d;
  logic        valid_q, valid_d;
  logic        perr_out_q, perr_out_d;
  logic        ferr_out_q, ferr_out_d;
  logic        ovr_q, ovr_d;

  logic        sample_pt;
  logic        last_bit;
  logic        done;

  assign rx_s = sync_q[Stages-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      cfg_div_q  <= '0;
      cfg_bpw_q  <= '0;
      cfg_pen_q  <= 1'b0;
      cfg_even_q <= 1'b0;
      cfg_two_q  <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[Stages-2:0], rx};
      rx_prev_q  <= rx_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      cfg_div_q  <= cfg_div_d;
      cfg_bpw_q  <= cfg_bpw_d;
      cfg_pen_q  <= cfg_pen_d;
      cfg_even_q <= cfg_even_d;
      cfg_two_q  <= cfg_two_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign sample_pt = (cnt_q == (cfg_div_q - 16'd1));
  // Out-of-range word lengths still terminate after 16 data bits.
  assign last_bit  = ({1'b0, bit_q} == cfg_bpw_q) || (bit_q == 4'hF);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    cfg_div_d  = cfg_div_q;
    cfg_bpw_d  = cfg_bpw_q;
    cfg_pen_d  = cfg_pen_q;
    cfg_even_d = cfg_even_q;
    cfg_two_d  = cfg_two_q;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Edge, not level, so a held break cannot retrigger.
        if (rx_prev_q && !rx_s) begin
          state_d    = StStart;
          cnt_d      = 16'd1;
          bit_d      = '0;
          shift_d    = '0;
          par_d      = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          cfg_div_d  = clk_div;
          cfg_bpw_d  = bits_per_word;
          cfg_pen_d  = parity_en;
          cfg_even_d = parity_even_odd;
          cfg_two_d  = two_stop_bit;
        end
      end
      StStart: begin
        if (cnt_q == (cfg_div_q >> 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (sample_pt) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          par_d          = par_q ^ rx_s;
          bit_d          = bit_q + 4'd1;
          if (last_bit) state_d = cfg_pen_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (sample_pt) begin
          cnt_d = '0;
          if (rx_s != (par_q ^ ~cfg_even_q)) perr_d = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        if (sample_pt) begin
          cnt_d = '0;
          if (!rx_s) ferr_d = 1'b1;
          if (cfg_two_q) begin
            state_d = StStop2;
          end else begin
            state_d = StIdle;
            done    = 1'b1;
          end
        end
      end
      StStop2: begin
        if (sample_pt) begin
          cnt_d = '0;
          if (!rx_s) ferr_d = 1'b1;
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_out_d = data_out_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = ovr_q;

    if (rd_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done) begin
      data_out_d = shift_q;
      perr_out_d = perr_q;
      ferr_out_d = ferr_d;
      valid_d    = 1'b1;
      if (valid_q && !rd_ack) ovr_d = 1'b1;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = valid_q;
  assign parity_err  = perr_out_q;
  assign frame_err   = ferr_out_q;
  assign overrun_err = ovr_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a behavioural serial transmitter feeds the DUT and pushes the
// expected word; an independent monitor acknowledges and checks each delivered word.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned Sync = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] clk_div = 16'd8;
  logic [4:0]  bits_per_word = 5'd7;
  logic        parity_en = 1'b0;
  logic        parity_even_odd = 1'b1;
  logic        two_stop_bit = 1'b0;
  logic        mon_ack = 1'b0;
  logic        man_ack = 1'b0;
  logic        rd_ack;
  logic [15:0] data_out;
  logic        data_valid, parity_err, frame_err, overrun_err, busy;

  assign rd_ack = mon_ack | man_ack;

  uart_rx #(.SYNC_STAGES(Sync)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .clk_div         (clk_div),
    .bits_per_word   (bits_per_word),
    .parity_en       (parity_en),
    .parity_even_odd (parity_even_odd),
    .two_stop_bit    (two_stop_bit),
    .rd_ack          (rd_ack),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .parity_err      (parity_err),
    .frame_err       (frame_err),
    .overrun_err     (overrun_err),
    .busy            (busy)
  );

  typedef struct {
    logic [15:0] d;
    logic        pe;
    logic        fe;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        auto_ack = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Serial transmitter plus reference model for the word it sends.
  task automatic send(input logic [15:0] d, input logic flip_par, input logic s1_low,
                      input logic s2_low, input logic scramble);
    int unsigned div, n, ones;
    logic        pen, ev, two, pbit;
    logic [15:0] w;
    logic [15:0] sv_div;
    logic [4:0]  sv_bpw;
    logic        sv_pen, sv_ev, sv_two;
    exp_t        e;
    div = clk_div;
    n   = bits_per_word + 1;
    pen = parity_en;
    ev  = parity_even_odd;
    two = two_stop_bit;
    sv_div = clk_div; sv_bpw = bits_per_word; sv_pen = pen; sv_ev = ev; sv_two = two;
    w = '0;
    for (int i = 0; i < int'(n); i++) w[i] = d[i];
    ones = $countones(w);
    pbit = ((ones % 2) == 1) ^ ~ev ^ flip_par;
    @(negedge clk);
    e.d   = w;
    e.pe  = pen && (((ones + pbit) % 2) == (ev ? 1 : 0));
    e.fe  = s1_low || (two && s2_low);
    e.due = cyc + Sync + div / 2 + div * (n + pen + 1 + two) + 1;
    if (auto_ack) exp_q.push_back(e);
    rx = 1'b0;
    repeat (div) @(negedge clk);
    if (scramble) begin
      clk_div         = 16'($urandom_range(4, 40));
      bits_per_word   = 5'($urandom_range(0, 15));
      parity_en       = ~pen;
      parity_even_odd = ~ev;
      two_stop_bit    = ~two;
    end
    for (int i = 0; i < int'(n); i++) begin
      rx = w[i];
      repeat (div) @(negedge clk);
    end
    if (pen) begin
      rx = pbit;
      repeat (div) @(negedge clk);
    end
    rx = ~s1_low;
    repeat (div) @(negedge clk);
    if (two) begin
      rx = ~s2_low;
      repeat (div) @(negedge clk);
    end
    rx = 1'b1;
    if (scramble) begin
      clk_div = sv_div; bits_per_word = sv_bpw; parity_en = sv_pen;
      parity_even_odd = sv_ev; two_stop_bit = sv_two;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || data_valid) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: consumes every word presented while auto_ack is on.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (auto_ack && data_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_word: got %0h, want none", data_out);
        end else begin
          e = exp_q.pop_front();
          check("data_out", data_out, e.d);
          check("parity_err", parity_err, e.pe);
          check("frame_err", frame_err, e.fe);
          check("latency", cyc, e.due);
          check("overrun_err", overrun_err, 0);
        end
        mon_ack = 1'b1;
        @(negedge clk);
        mon_ack = 1'b0;
      end
    end
  end

  initial begin
    int unsigned t;
    exp_t        e;

    repeat (4) @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun_err", overrun_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    auto_ack = 1'b1;

    send(16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Half-bit glitch must be rejected as a false start.
    @(negedge clk);
    t = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_high", busy, 1);
    repeat (3) @(negedge clk);
    check("glitch_busy_dropped", busy, 0);
    repeat (20) @(negedge clk);
    check("glitch_no_word", data_valid, 0);

    parity_en = 1'b1; parity_even_odd = 1'b1;
    send(16'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    send(16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    parity_en = 1'b0; two_stop_bit = 1'b1;
    send(16'h005A, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    two_stop_bit = 1'b0; bits_per_word = 5'd15;
    send(16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Config changes mid-frame must not disturb the frame in flight.
    bits_per_word = 5'd7; clk_div = 16'd10; parity_en = 1'b1; parity_even_odd = 1'b0;
    send(16'h003C, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Break: zero word with frame error, no restart while the line stays low.
    clk_div = 16'd8; parity_en = 1'b0;
    @(negedge clk);
    e.d = 16'h0000; e.pe = 1'b0; e.fe = 1'b1;
    e.due = cyc + Sync + 4 + 8 * 9 + 1;
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (120) @(negedge clk);
    check("break_no_restart", busy, 0);
    rx = 1'b1;
    drain();
    send(16'h0081, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    auto_ack = 1'b0;
    send(16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h0022, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("ovr_data_out", data_out, 16'h0022);
    check("ovr_data_valid", data_valid, 1);
    check("ovr_flag", overrun_err, 1);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check("ack_data_valid", data_valid, 0);
    check("ack_overrun_clear", overrun_err, 0);
    check("ack_data_hold", data_out, 16'h0022);
    repeat (3) @(negedge clk);
    auto_ack = 1'b1;

    for (int i = 0; i < 100; i++) begin
      clk_div         = 16'($urandom_range(4, 16));
      bits_per_word   = 5'($urandom_range(0, 15));
      parity_en       = 1'($urandom_range(0, 1));
      parity_even_odd = 1'($urandom_range(0, 1));
      two_stop_bit    = 1'($urandom_range(0, 1));
      send(16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    drain();

    // Reset mid-frame with an unread, flagged word in the holding register.
    auto_ack = 1'b0;
    clk_div = 16'd8; bits_per_word = 5'd7; parity_en = 1'b1; parity_even_odd = 1'b1;
    two_stop_bit = 1'b0;
    send(16'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_rst_parity_err", parity_err, 1);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_data_out", data_out, 0);
    check("midrst_data_valid", data_valid, 0);
    check("midrst_parity_err", parity_err, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_overrun_err", overrun_err, 0);
    check("midrst_busy", busy, 0);
    rx = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
